ws281x_strip_driver: RTL and testbench
======================================

# ws281x_strip_driver

Parametrised WS281x serial LED strip driver: accepts one pixel per valid/ready handshake and emits the single-wire NRZ waveform with cycle-exact high/low times. It supports any clock frequency, 3- or 4-channel pixels (RGB/RGBW), selectable colour order, gapless back-to-back pixels, and automatic latch (reset) generation after the frame's last pixel. It sits between the pixel-sequencing logic and the strip data pin, replacing the fixed-timing 24-bit pixel driver.

## Interface
Parameters:
- CLK_HZ, 16_000_000: input clock frequency.
- T0H_NS, 350: high time for a 0 bit.
- T1H_NS, 700: high time for a 1 bit.
- TBIT_NS, 1250: total bit period.
- TRESET_US, 80: latch low time after the last pixel.
- CHANNELS, 3: bytes per pixel; legal values are 3 and 4.
- ORDER, 0: 0 = G,R,B[,W] on the wire; 1 = R,G,B[,W].

Derived cycle counts use ceiling division: N = ceil(T × CLK_HZ / 1e9). At defaults T0H=6, T1H=12, TBIT=20 and TRESET=1280 cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_color  in  8*CHANNELS  pixel, packed {R,G,B[,W]}, R in the MSBs
- s_valid  in  1  pixel offered
- s_last  in  1  pixel is the frame's last; sampled with s_color
- s_ready  out  1  driver accepts a pixel this cycle
- brightness  in  8  global scale; used only with the brightness macro
- dout  out  1  strip data line
- busy  out  1  high in any state other than IDLE
- underrun  out  1  one-cycle pulse, see WAIT

## Operation
- A transfer occurs on a rising edge where s_valid && s_ready. The accepted pixel is reordered per ORDER, then loaded into a shift register of 8*CHANNELS bits. Bits are sent MSB first.
- Bit encoding:
  - A bit counter runs 0..TBIT-1.
  - dout = (cnt < (bit ? T1H : T0H)).
  - dout is registered.
- States:
  - IDLE: dout=0, s_ready=1. A transfer moves to SEND.
  - SEND: emits the pixel bits. s_ready=1 only on the final cycle of the final bit, and only if the current pixel is not last.
    - Transfer on that cycle: next pixel loaded, SEND continues with no gap.
    - No transfer on that cycle: move to WAIT.
    - Final bit of a last pixel: move to LATCH.
  - WAIT: dout=0, s_ready=1. A transfer moves to SEND. If WAIT lasts TRESET cycles, pulse underrun for one cycle and go to IDLE; the strip has latched a partial frame.
  - LATCH: dout=0, s_ready=0 for TRESET cycles, then IDLE.
- s_last is ignored once the pixel has been accepted. Changing s_color or s_valid without a transfer has no effect.
- Reset (asynchronous, any state): dout=0, busy=0, underrun=0, state=IDLE, so s_ready=1. The bit counter, bit index and shift register clear. A reset mid-pixel truncates the waveform immediately.

## Timing
- Transfer at edge k: dout rises at edge k+1, the first cycle of bit 0.
- Pixel period is exactly 8*CHANNELS*TBIT cycles: 480 at defaults.
- Back-to-back pixels produce one continuous bit stream with no extra cycles.
- Latch: dout stays low for TRESET cycles starting after the last bit's final cycle. busy falls on the edge that enters IDLE.
- Throughput: one pixel per pixel period. The driver never buffers more than one pixel.

## Configuration
- WS281X_BRIGHTNESS_EN defined:
  - Each channel byte c is replaced before reordering by (c × (brightness+1)) >> 8, computed in 16 bits and truncated to 8 bits.
  - brightness=255 is identity; brightness=0 gives all zero.
  - brightness is sampled at the transfer edge. No latency is added.
- WS281X_BRIGHTNESS_EN undefined: the brightness port is ignored, and s_color is sent unmodified.

## Test plan
- Defaults, single pixel s_color=24'hFF0000, s_last=1 → wire order G,R,B; 8 bits of 6-high/14-low, then 8 bits of 12-high/8-low, then 8 bits of 6-high/14-low; then 1280 low cycles; busy low after that.
- Two pixels 24'h00FF00, 24'h0000FF held valid, second with last → 960 contiguous bit cycles, s_ready high exactly once in SEND (cycle 479), no gap between pixels.
- CHANNELS=4, ORDER=1, pixel 32'h80000001 → 32 bits: first bit 1 (12 high), bits 1..30 = 0, bit 31 = 1; 640-cycle pixel.
- Non-last pixel with s_valid dropped afterward → WAIT, dout low; underrun pulses at WAIT cycle 1280, then IDLE. Repeat with a pixel offered at WAIT cycle 100 → resumes SEND, no underrun.
- reset_n asserted mid-bit (dout high) → dout low asynchronously, busy=0, s_ready=1; the next transfer restarts from bit 0.
- With WS281X_BRIGHTNESS_EN, brightness=127, pixel 24'hFF8001 → sent bytes G=0x40, R=0x7F, B=0x00.

Source files
------------

// File: rtl/ws281x_strip_driver.sv
// rtl/ws281x_strip_driver.sv - WS281x single-wire NRZ LED strip driver
//
// Takes one pixel per s_valid/s_ready handshake and serialises it MSB first.
// Each bit lasts TBIT cycles and is high for T0H or T1H cycles. The next pixel
// is accepted on the last cycle of the current one, so a steady supply of
// pixels gives a gapless bit stream. After a pixel flagged s_last the line is
// held low for TRESET cycles (LATCH). If the source stalls mid-frame, the
// driver waits (WAIT). If the stall lasts a full latch time, it reports an
// underrun and returns to IDLE.
//
// Optional feature macro: WS281X_BRIGHTNESS_EN. When it is defined, every
// channel byte is scaled by (brightness+1)/256 at the transfer edge.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   s_color     pixel {R,G,B[,W]}, R in the MSBs
//   s_valid     pixel offered
//   s_last      offered pixel ends the frame
//   s_ready     driver accepts a pixel this cycle
//   brightness  global scale (only with WS281X_BRIGHTNESS_EN)
//   dout        registered strip data line
//   busy        high whenever the driver is not idle
//   underrun    one-cycle pulse when a stalled frame times out

module ws281x_strip_driver #(
    parameter int CLK_HZ    = 16_000_000,
    parameter int T0H_NS    = 350,
    parameter int T1H_NS    = 700,
    parameter int TBIT_NS   = 1250,
    parameter int TRESET_US = 80,
    parameter int CHANNELS  = 3,
    parameter int ORDER     = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [8*CHANNELS-1:0] s_color,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic [7:0]            brightness,
    output logic                  dout,
    output logic                  busy,
    output logic                  underrun
);

    localparam longint NS_PER_S = 1_000_000_000;
    localparam longint US_PER_S = 1_000_000;

    // Round every time up to whole clock cycles.
    localparam int T0H_CYC    = int'((longint'(T0H_NS) * longint'(CLK_HZ) + NS_PER_S - 1) / NS_PER_S);
    localparam int T1H_CYC    = int'((longint'(T1H_NS) * longint'(CLK_HZ) + NS_PER_S - 1) / NS_PER_S);
    localparam int TBIT_CYC   = int'((longint'(TBIT_NS) * longint'(CLK_HZ) + NS_PER_S - 1) / NS_PER_S);
    localparam int TRESET_CYC = int'((longint'(TRESET_US) * longint'(CLK_HZ) + US_PER_S - 1) / US_PER_S);

    localparam int NBITS   = 8 * CHANNELS;
    localparam int MAX_A   = (T1H_CYC > TBIT_CYC) ? T1H_CYC : TBIT_CYC;
    localparam int CNT_MAX = (TRESET_CYC > MAX_A) ? TRESET_CYC : MAX_A;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NBITS);

    localparam logic [CW-1:0] T0H_C        = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_C        = CW'(T1H_CYC);
    localparam logic [CW-1:0] TBIT_LAST    = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] TRESET_LAST  = CW'(TRESET_CYC - 1);
    localparam logic [IW-1:0] BIT_IDX_LAST = IW'(NBITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_LATCH
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      bit_idx;
    logic [NBITS-1:0]   shreg;
    logic               last_q;

    logic [NBITS-1:0]   scaled;
    logic [NBITS-1:0]   wire_word;
    logic               bit_end;
    logic               pix_end;
    logic               xfer;

`ifdef WS281X_BRIGHTNESS_EN
    // (c * (b + 1)) >> 8; the product always fits in 16 bits.
    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

    always_comb begin
        scaled = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            scaled[8*i +: 8] = scale_byte(s_color[8*i +: 8], brightness);
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign scaled = s_color;
`endif

    // ORDER 0 puts green first on the wire: swap the two top bytes.
    generate
        if (ORDER == 0) begin : g_grb
            assign wire_word = {scaled[NBITS-9 -: 8], scaled[NBITS-1 -: 8], scaled[NBITS-17:0]};
        end else begin : g_rgb
            assign wire_word = scaled;
        end
    endgenerate

    assign bit_end = (state == ST_SEND) && (cnt == TBIT_LAST);
    assign pix_end = bit_end && (bit_idx == BIT_IDX_LAST);

    // In SEND the handshake opens only on the very last cycle of a pixel.
    // The next pixel then follows without an idle bit slot.
    assign s_ready = (state == ST_IDLE) || (state == ST_WAIT) || (pix_end && !last_q);
    assign xfer    = s_valid && s_ready;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            last_q   <= 1'b0;
            dout     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            // The line follows the bit counter one cycle later.
            dout     <= (state == ST_SEND) && (cnt < (shreg[NBITS-1] ? T1H_C : T0H_C));

            if (xfer) begin
                state   <= ST_SEND;
                shreg   <= wire_word;
                last_q  <= s_last;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                    end
                    ST_SEND: begin
                        if (bit_end) begin
                            cnt <= '0;
                            if (bit_idx == BIT_IDX_LAST) begin
                                state <= last_q ? ST_LATCH : ST_WAIT;
                            end else begin
                                bit_idx <= bit_idx + IW'(1);
                                shreg   <= {shreg[NBITS-2:0], 1'b0};
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_WAIT: begin
                        // A stall as long as the latch time means the strip
                        // has already latched a partial frame.
                        if (cnt == TRESET_LAST) begin
                            state    <= ST_IDLE;
                            cnt      <= '0;
                            underrun <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_LATCH: begin
                        if (cnt == TRESET_LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ws281x_strip_driver.sv
// tb/tb_ws281x_strip_driver.sv - self-checking bench for ws281x_strip_driver

module tb_ws281x_strip_driver;

    localparam int TB = 20;
    localparam int T0 = 6;
    localparam int T1 = 12;
    localparam int TR = 1280;
`ifdef WS281X_BRIGHTNESS_EN
    localparam bit BRI_EN = 1'b1;
`else
    localparam bit BRI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] col;
    logic        vld;
    logic        lst;
    logic [7:0]  bri;
    logic        sel4;

    logic rdy3, dout3, busy3, und3;
    logic rdy4, dout4, busy4, und4;
    logic v3, v4;
    logic rdy_s, dout_s, busy_s, und_s;

    assign v3     = vld & ~sel4;
    assign v4     = vld & sel4;
    assign rdy_s  = sel4 ? rdy4 : rdy3;
    assign dout_s = sel4 ? dout4 : dout3;
    assign busy_s = sel4 ? busy4 : busy3;
    assign und_s  = sel4 ? und4 : und3;

    ws281x_strip_driver u_dut3 (
        .clk(clk), .reset_n(reset_n), .s_color(col[23:0]), .s_valid(v3), .s_last(lst),
        .s_ready(rdy3), .brightness(bri), .dout(dout3), .busy(busy3), .underrun(und3)
    );

    ws281x_strip_driver #(.CHANNELS(4), .ORDER(1)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .s_color(col), .s_valid(v4), .s_last(lst),
        .s_ready(rdy4), .brightness(bri), .dout(dout4), .busy(busy4), .underrun(und4)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a timeline of accepted pixels in absolute edge numbers.
    int          cyc = 0;
    bit          m_started, p_valid, m_last, xfer;
    int          m_acc, p_acc, m_end;
    logic [31:0] m_bits, p_bits;
    bit          wave [640];

    typedef struct {
        bit          s4;
        logic [31:0] col;
        logic [7:0]  bri;
        logic [31:0] ww;
    } vec_t;
    vec_t vecs[$];

    function automatic int nbits();
        return sel4 ? 32 : 24;
    endfunction

    function automatic logic [31:0] wire_of(logic [31:0] c, logic [7:0] b, int nch, int ord);
        logic [7:0]  ch [4];
        logic [7:0]  t;
        logic [31:0] w;
        for (int k = 0; k < 4; k++) ch[k] = 8'd0;
        for (int k = 0; k < nch; k++) begin
            ch[k] = c[8*(nch-1-k) +: 8];
            if (BRI_EN) ch[k] = 8'((int'(ch[k]) * (int'(b) + 1)) / 256);
        end
        if (ord == 0) begin
            t = ch[0]; ch[0] = ch[1]; ch[1] = t;
        end
        w = 32'd0;
        for (int k = 0; k < nch; k++) w = (w << 8) | {24'd0, ch[k]};
        return w;
    endfunction

    function automatic bit lvl(logic [31:0] bits, int acc, int e);
        int j;
        bit b;
        j = e - 1 - acc;
        if (j < 0 || j >= nbits() * TB) return 1'b0;
        b = bits[nbits() - 1 - j / TB];
        return (j % TB) < (b ? T1 : T0);
    endfunction

    function automatic bit mdl_ready(int e);
        if (!m_started) return 1'b1;
        if (e < m_end) return 1'b0;
        if (!m_last) return 1'b1;
        return e > m_end + TR;
    endfunction

    function automatic bit mdl_busy(int e);
        return m_started && (e < m_end + TR);
    endfunction

    function automatic bit mdl_under(int e);
        return m_started && !m_last && (e == m_end + TR);
    endfunction

    function automatic bit exp_dout(int e);
        return (m_started && lvl(m_bits, m_acc, e)) || (p_valid && lvl(p_bits, p_acc, e));
    endfunction

    task automatic mdl_reset();
        m_started = 1'b0;
        p_valid   = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        xfer = 1'b0;
        if (reset_n && vld && mdl_ready(cyc)) begin
            p_bits    = m_bits;
            p_acc     = m_acc;
            p_valid   = m_started;
            m_bits    = wire_of(col, bri, sel4 ? 4 : 3, sel4 ? 1 : 0);
            m_acc     = cyc;
            m_end     = cyc + nbits() * TB;
            m_last    = lst;
            m_started = 1'b1;
            xfer      = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        chk("dout", {31'd0, dout_s}, {31'd0, exp_dout(cyc)});
        chk("s_ready", {31'd0, rdy_s}, {31'd0, mdl_ready(cyc + 1)});
        chk("busy", {31'd0, busy_s}, {31'd0, mdl_busy(cyc)});
        chk("underrun", {31'd0, und_s}, {31'd0, mdl_under(cyc)});
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (busy_s && n < 5000) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, busy_s}, 32'd0);
    endtask

    // Sends one last pixel from IDLE, decodes the waveform bit by bit and
    // measures the latch that follows.
    task automatic send_vec(input vec_t v);
        int errs, h, n, highs, nb;
        logic [31:0] word;
        sel4 = v.s4;
        mdl_reset();
        nb  = nbits();
        vld = 1'b1; col = v.col; lst = 1'b1; bri = v.bri;
        tick();
        vld = 1'b0; col = $urandom;
        chk("vec_busy", {31'd0, busy_s}, 32'd1);
        for (int k = 0; k < nb * TB; k++) begin
            tick();
            wave[k] = dout_s;
        end
        errs = 0;
        word = 32'd0;
        for (int i = 0; i < nb; i++) begin
            h = 0;
            while (h < TB && wave[i*TB + h]) h++;
            for (int k = h; k < TB; k++) if (wave[i*TB + k]) errs++;
            if (h != T0 && h != T1) errs++;
            word = (word << 1) | {31'd0, (h == T1)};
        end
        chk("vec_shape", errs, 0);
        chk("vec_word", word, v.ww);
        n = 0;
        highs = 0;
        while (busy_s && n < 5000) begin
            tick();
            n++;
            highs += int'(dout_s);
        end
        chk("vec_latch_len", n, TR);
        chk("vec_latch_low", highs, 0);
    endtask

    initial begin
        int a, a1, a2, n, nrdy, rdy_at, nund;

        vecs.push_back('{s4: 1'b0, col: 32'h00FF0000, bri: 8'hFF, ww: 32'h0000FF00});
        vecs.push_back('{s4: 1'b0, col: 32'h0000FF00, bri: 8'hFF, ww: 32'h00FF0000});
        vecs.push_back('{s4: 1'b0, col: 32'h000000FF, bri: 8'hFF, ww: 32'h000000FF});
        vecs.push_back('{s4: 1'b0, col: 32'h00123456, bri: 8'hFF, ww: 32'h00341256});
        vecs.push_back('{s4: 1'b0, col: 32'h00A5C3E7, bri: 8'hFF, ww: 32'h00C3A5E7});
`ifdef WS281X_BRIGHTNESS_EN
        vecs.push_back('{s4: 1'b0, col: 32'h00FF8001, bri: 8'd127, ww: 32'h00407F00});
        vecs.push_back('{s4: 1'b0, col: 32'h00FFFFFF, bri: 8'd0, ww: 32'h00000000});
`endif
        vecs.push_back('{s4: 1'b1, col: 32'h80000001, bri: 8'hFF, ww: 32'h80000001});
        vecs.push_back('{s4: 1'b1, col: 32'h11223344, bri: 8'hFF, ww: 32'h11223344});

        reset_n = 1'b0; vld = 1'b0; col = 32'd0; lst = 1'b0; bri = 8'hFF; sel4 = 1'b0;
        mdl_reset();
        repeat (3) tick();
        chk("rst_ready", {31'd0, rdy_s}, 32'd1);
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        chk("rst_dout", {31'd0, dout_s}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Two pixels offered back to back; the second one ends the frame.
        vld = 1'b1; col = 32'h0000FF00; lst = 1'b0;
        tick();
        a1 = cyc;
        col = 32'h000000FF; lst = 1'b1;
        nrdy = 0; rdy_at = -1; n = 0;
        xfer = 1'b0;
        while (!xfer && n < 2000) begin
            if (rdy_s && busy_s) begin
                nrdy++;
                rdy_at = cyc - a1;
            end
            tick();
            n++;
        end
        a2 = cyc;
        vld = 1'b0;
        chk("b2b_ready_count", nrdy, 1);
        chk("b2b_ready_cycle", rdy_at, 479);
        chk("b2b_gap", a2 - a1, 480);
        nrdy = 0; n = 0;
        while (busy_s && n < 5000) begin
            if (rdy_s) nrdy++;
            tick();
            n++;
        end
        chk("b2b_ready_after_last", nrdy, 0);
        chk("b2b_idle", {31'd0, busy_s}, 32'd0);

        // A non-last pixel, then the source stalls.
        vld = 1'b1; col = 32'h00123456; lst = 1'b0;
        tick();
        a = cyc;
        vld = 1'b0;
        n = 0;
        while (!und_s && n < 3000) begin
            tick();
            n++;
        end
        chk("underrun_edge", cyc - a, 480 + TR);
        tick();
        chk("underrun_one_cycle", {31'd0, und_s}, 32'd0);
        chk("underrun_idle", {31'd0, busy_s}, 32'd0);

        // The same stall, resumed at WAIT cycle 100.
        vld = 1'b1; col = 32'h00654321; lst = 1'b0;
        tick();
        a = cyc;
        vld = 1'b0;
        while (cyc < a + 580) tick();
        vld = 1'b1; col = 32'h00FF0000; lst = 1'b1;
        tick();
        vld = 1'b0;
        tick();
        chk("resume_dout", {31'd0, dout_s}, 32'd1);
        nund = 0; n = 0;
        while (busy_s && n < 5000) begin
            tick();
            n++;
            if (und_s) nund++;
        end
        chk("resume_no_underrun", nund, 0);

        // Asynchronous reset in the middle of a high phase.
        vld = 1'b1; col = 32'h0000FF00; lst = 1'b1;
        tick();
        vld = 1'b0;
        repeat (3) tick();
        chk("pre_reset_dout", {31'd0, dout_s}, 32'd1);
        #2;
        reset_n = 1'b0;
        mdl_reset();
        #1;
        chk("async_rst_dout", {31'd0, dout_s}, 32'd0);
        chk("async_rst_busy", {31'd0, busy_s}, 32'd0);
        chk("async_rst_ready", {31'd0, rdy_s}, 32'd1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        send_vec('{s4: 1'b0, col: 32'h00FF0000, bri: 8'hFF, ww: 32'h0000FF00});

        // Randomised traffic: a busy phase, then a sparse phase that stalls.
        for (int k = 0; k < 12000; k++) begin
            vld = ($urandom_range(999) < ((k < 6000) ? 800 : 1));
            col = $urandom;
            lst = ($urandom_range(9) < 3);
            bri = 8'($urandom);
            tick();
        end
        vld = 1'b0;
        bri = 8'hFF;
        drain("random_drain");

        foreach (vecs[i]) send_vec(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
